// File: rtl/tmds_dc_balance.sv
// rtl/tmds_dc_balance.sv - TMDS stage-2 DC balancing with control/guard-band symbol insertion
// Two-stage valid/ready pipeline: stage A holds the beat plus its ones count, stage B the symbol and tally.
module tmds_dc_balance #(
  parameter int GUARD_CHANNEL = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       s_valid_in,
  output logic       s_ready_out,
  input  logic [8:0] qm_in,
  input  logic [1:0] ctrl_in,
  input  logic [1:0] mode_in,
  output logic       m_valid_out,
  input  logic       m_ready_in,
  output logic [9:0] tmds_out,
  output logic [4:0] tally_out
);

  localparam logic [1:0] MODE_VIDEO = 2'b01;
  localparam logic [1:0] MODE_GUARD = 2'b10;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GUARD_SYM = (GUARD_CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  logic       adv;
  logic       a_valid;
  logic [8:0] a_qm;
  logic [1:0] a_mode;
  logic [1:0] a_ctrl;
  logic [3:0] a_n1;
  logic [3:0] n1_in;

  logic [4:0] tally;
  logic [4:0] diff;
  logic [4:0] tally_nxt;
  logic [9:0] sym_nxt;
  logic [7:0] d;
  logic       q8;
  logic       tally_zero;
  logic       tally_pos;
  logic       tally_neg;
  logic       n1_gt;
  logic       n1_lt;

  assign adv         = !m_valid_out || m_ready_in;
  assign s_ready_out = adv;
  assign tally_out   = tally;

  always_comb begin
    n1_in = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1_in = n1_in + {3'b000, qm_in[i]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_valid <= 1'b0;
      a_qm    <= 9'd0;
      a_mode  <= 2'd0;
      a_ctrl  <= 2'd0;
      a_n1    <= 4'd0;
    end else if (adv) begin
      a_valid <= s_valid_in;
      if (s_valid_in) begin
        a_qm   <= qm_in;
        a_mode <= mode_in;
        a_ctrl <= ctrl_in;
        a_n1   <= n1_in;
      end
    end
  end

  // diff = n1 - n0 = 2*n1 - 8, computed modulo 32 as a 5-bit two's complement value
  assign d          = a_qm[7:0];
  assign q8         = a_qm[8];
  assign diff       = {a_n1, 1'b0} - 5'd8;
  assign tally_zero = (tally == 5'd0);
  assign tally_pos  = !tally[4] && !tally_zero;
  assign tally_neg  = tally[4];
  assign n1_gt      = (a_n1 > 4'd4);
  assign n1_lt      = (a_n1 < 4'd4);

  always_comb begin
    sym_nxt   = CTRL_00;
    tally_nxt = 5'd0;
    if (a_mode == MODE_VIDEO) begin
      if (tally_zero || (a_n1 == 4'd4)) begin
        sym_nxt   = {~q8, q8, (q8 ? d : ~d)};
        tally_nxt = q8 ? (tally + diff) : (tally - diff);
      end else if ((tally_pos && n1_gt) || (tally_neg && n1_lt)) begin
        sym_nxt   = {1'b1, q8, ~d};
        tally_nxt = tally + {3'b000, q8, 1'b0} - diff;
      end else begin
        sym_nxt   = {1'b0, q8, d};
        tally_nxt = tally + diff - {3'b000, ~q8, 1'b0};
      end
    end else if (a_mode == MODE_GUARD) begin
      sym_nxt = GUARD_SYM;
    end else begin
      case (a_ctrl)
        2'b00:   sym_nxt = CTRL_00;
        2'b01:   sym_nxt = CTRL_01;
        2'b10:   sym_nxt = CTRL_10;
        default: sym_nxt = CTRL_11;
      endcase
    end
  end

  // Symbol and tally only move on a real beat; an empty stage A just drops m_valid_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_valid_out <= 1'b0;
      tmds_out    <= 10'd0;
      tally       <= 5'd0;
    end else if (adv) begin
      m_valid_out <= a_valid;
      if (a_valid) begin
        tmds_out <= sym_nxt;
        tally    <= tally_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tmds_dc_balance.sv
// tb/tb_tmds_dc_balance.sv - scoreboard bench for tmds_dc_balance with hand-computed vectors
module tb_tmds_dc_balance;

  logic       clk_in;
  logic       rst_n_in;
  logic       s_valid_in;
  logic       s_ready_out;
  logic [8:0] qm_in;
  logic [1:0] ctrl_in;
  logic [1:0] mode_in;
  logic       m_valid_out;
  logic       m_ready_in;
  logic [9:0] tmds_out;
  logic [4:0] tally_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] sym;
    logic [4:0] tly;
  } exp_t;

  exp_t sb[$];

  logic [8:0] vq [12] = '{9'b0_0000_1111, 9'b1_0000_0001, 9'b0_0000_0011, 9'b1_1110_0000,
                          9'b0_0011_1111, 9'b1_0111_1111, 9'b0_0000_0111, 9'b0_1010_1010,
                          9'b1_1100_0011, 9'b0_1111_1110, 9'b1_0000_1111, 9'b0_1111_1111};
  logic [9:0] vs [12] = '{10'b1011110000, 10'b0100000001, 10'b1011111100, 10'b1100011111,
                          10'b1011000000, 10'b0101111111, 10'b0000000111, 10'b1001010101,
                          10'b0111000011, 10'b1000000001, 10'b0100001111, 10'b0011111111};
  logic [4:0] vt [12] = '{5'd0, 5'h1A, 5'h1E, 5'd2, 5'h1E, 5'd4, 5'd0, 5'd0, 5'd0, 5'h1A, 5'h1A, 5'd0};

  tmds_dc_balance #(.GUARD_CHANNEL(1)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .s_valid_in  (s_valid_in),
    .s_ready_out (s_ready_out),
    .qm_in       (qm_in),
    .ctrl_in     (ctrl_in),
    .mode_in     (mode_in),
    .m_valid_out (m_valid_out),
    .m_ready_in  (m_ready_in),
    .tmds_out    (tmds_out),
    .tally_out   (tally_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drivers run at posedge+2 so that acceptance is judged on settled s_ready_out.
  task automatic send(input logic [8:0] qm, input logic [1:0] mode, input logic [1:0] ctrl,
                      input logic [9:0] es, input logic [4:0] et);
    int n;
    exp_t e;
    n = 0;
    s_valid_in = 1'b1;
    qm_in      = qm;
    mode_in    = mode;
    ctrl_in    = ctrl;
    while (!s_ready_out && n < 100) begin
      @(posedge clk_in);
      #2;
      n++;
    end
    if (!s_ready_out) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end else begin
      e.sym = es;
      e.tly = et;
      sb.push_back(e);
    end
    @(posedge clk_in);
    #2;
    s_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk_in);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && m_valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_symbol actual=%b required=none", tmds_out);
      end else begin
        chk("tmds_out", 32'(tmds_out), 32'(sb[0].sym));
        chk("tally_out", 32'(tally_out), 32'(sb[0].tly));
        if (m_ready_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n_in   = 1'b0;
    s_valid_in = 1'b0;
    qm_in      = 9'd0;
    ctrl_in    = 2'd0;
    mode_in    = 2'd0;
    m_ready_in = 1'b1;
    #2;
    chk("rst_m_valid", 32'(m_valid_out), 32'd0);
    chk("rst_tmds", 32'(tmds_out), 32'd0);
    chk("rst_tally", 32'(tally_out), 32'd0);
    chk("rst_s_ready", 32'(s_ready_out), 32'd1);
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #2;

    send(9'd0, 2'b00, 2'b01, 10'b0010101011, 5'd0);
    chk("latency_stage_a", 32'(m_valid_out), 32'd0);
    @(posedge clk_in);
    #2;
    chk("latency_stage_b", 32'(m_valid_out), 32'd1);

    send(9'b1_1111_1111, 2'b01, 2'b00, 10'b0111111111, 5'd8);
    send(9'b1_1111_1111, 2'b01, 2'b00, 10'b1100000000, 5'd2);
    send(9'd0, 2'b10, 2'b00, 10'b0100110011, 5'd0);
    send(9'd0, 2'b00, 2'b00, 10'b1101010100, 5'd0);
    send(9'd0, 2'b00, 2'b10, 10'b0101010100, 5'd0);
    send(9'd0, 2'b00, 2'b11, 10'b1010101011, 5'd0);
    send(9'd0, 2'b11, 2'b00, 10'b1101010100, 5'd0);

    fork
      begin
        for (int i = 0; i < 12; i++) send(vq[i], 2'b01, 2'b00, vs[i], vt[i]);
      end
      begin
        repeat (5) @(posedge clk_in);
        #1;
        m_ready_in = 1'b0;
        repeat (3) begin
          #3;
          chk("stall_s_ready", 32'(s_ready_out), 32'd0);
          chk("stall_m_valid", 32'(m_valid_out), 32'd1);
          @(posedge clk_in);
          #1;
        end
        m_ready_in = 1'b1;
      end
    join
    drain();

    send(vq[1], 2'b01, 2'b00, vs[1], vt[1]);
    repeat (3) begin
      @(posedge clk_in);
      #2;
    end
    chk("bubble_m_valid", 32'(m_valid_out), 32'd0);
    chk("bubble_tmds", 32'(tmds_out), 32'(vs[1]));
    chk("bubble_tally", 32'(tally_out), 32'h1A);

    send(vq[2], 2'b01, 2'b00, 10'b1011111100, 5'd4);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_tmds", 32'(tmds_out), 32'd0);
    chk("async_rst_tally", 32'(tally_out), 32'd0);
    chk("async_rst_m_valid", 32'(m_valid_out), 32'd0);
    chk("async_rst_s_ready", 32'(s_ready_out), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #2;
    send(vq[2], 2'b01, 2'b00, 10'b1011111100, 5'd4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
